reg_file_fwd: RTL
=================

// Module: reg_file_fwd
// PURPOSE
//  Parametrised register file for the ID stage: two registered read ports, one write port,
//  write-first bypass and EX/DM/WB operand forwarding with an immediate override on B.
//  Clears the array after reset with an init sweep, one entry per cycle.
//  Feeds operands A/B to the ALU; written back from the DM stage.
// PARAMETERS
//  DATA_W  8   operand / register width in bits
//  DEPTH   32  number of registers (power of 2, >= 2)
//  ADDR_W  $clog2(DEPTH)  register address width (derived, not overridden)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  rd_en      in   1       1: capture new read operands this cycle; 0: hold (stall)
//  ra_addr    in   ADDR_W  read port A address
//  rb_addr    in   ADDR_W  read port B address
//  wr_en      in   1       write strobe
//  wr_addr    in   ADDR_W  write address
//  wr_data    in   DATA_W  write data
//  ans_ex     in   DATA_W  forwarded EX result
//  ans_dm     in   DATA_W  forwarded DM result
//  ans_wb     in   DATA_W  forwarded WB result
//  fwd_sel_a  in   2       A source: 00 reg, 01 EX, 10 DM, 11 WB
//  fwd_sel_b  in   2       B source, same encoding
//  imm        in   DATA_W  immediate operand
//  imm_sel    in   1       1: B = imm (overrides fwd_sel_b)
//  a          out  DATA_W  operand A
//  b          out  DATA_W  operand B
//  init_busy  out  1       1 while the clear sweep runs
// BEHAVIOUR
//  - FSM: INIT, RUN. rst=1 -> INIT, sweep counter=0, read regs AR/BR=0 (reset value of a/b=0
//    when fwd_sel=00 and imm_sel=0), init_busy=1.
//  - INIT: each cycle writes 0 to entry[cnt], cnt++; at cnt==DEPTH-1 write, next state RUN.
//    Sweep takes exactly DEPTH cycles after rst deasserts; init_busy falls on cycle DEPTH.
//    wr_en ignored and AR/BR held at 0 during INIT. rst mid-sweep restarts at entry 0.
//  - RUN: wr_en=1 writes wr_data to entry[wr_addr] on clk edge.
//  - Read latency 1 cycle: on edge with rd_en=1, AR<=entry[ra_addr], BR<=entry[rb_addr].
//    rd_en=0 holds AR/BR unchanged; writes still occur while stalled.
//  - Write-first bypass: same edge wr_en=1 and wr_addr==ra_addr (or rb_addr) -> AR (BR)
//    captures wr_data, not stale array value. Both ports may bypass together.
//  - a/b combinational from AR/BR, ans_*, imm per selects; no extra register stage.
//  - No arithmetic; all paths DATA_W wide, no truncation or extension.
// CONFIGURATION
//  REGFILE_ZERO_REG_EN defined: entry 0 hard-wired to 0; writes to addr 0 dropped, bypass
//   to addr 0 suppressed, reads of addr 0 return 0 in every state.
//  Undefined: entry 0 is an ordinary register.
// STRUCTURE
//  Package regfile_pkg: fwd_sel encodings (FWD_REG/EX/DM/WB), FSM state encodings.
//  Sub-module fwd_mux (4:1 DATA_W select), instantiated twice; imm mux stays in top.
// TESTING
//  1 rst 1 cycle, poll: init_busy high exactly 32 cycles; then read all 32 addrs -> all 0.
//  2 write 0xA5 to r7, next cycle read ra=7 -> a=0xA5 one cycle after rd_en.
//  3 same edge wr r3=0x3C and ra=rb=3 -> a=b=0x3C (bypass), not old value.
//  4 AR=0x11, rd_en=0 for 3 cycles while r-addr changes -> a stays 0x11.
//  5 fwd_sel_a=01/10/11 with ans_ex=0x01,dm=0x02,wb=0x03 -> a=0x01/0x02/0x03;
//    imm_sel=1, imm=0x7F -> b=0x7F regardless of fwd_sel_b.
//  6 rst at sweep cycle 10, wr_en=1 during INIT -> sweep restarts, write ignored;
//    with REGFILE_ZERO_REG_EN: write 0xFF to r0 -> read r0 = 0x00.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - operand forwarding select encodings and init/run FSM states
package regfile_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_DM  = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - 4:1 operand source select (register / EX / DM / WB)
module fwd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] reg_i,
    input  logic [DATA_W-1:0] ex_i,
    input  logic [DATA_W-1:0] dm_i,
    input  logic [DATA_W-1:0] wb_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = reg_i;
        case (sel_i)
            FWD_EX:  y_o = ex_i;
            FWD_DM:  y_o = dm_i;
            FWD_WB:  y_o = wb_i;
            default: y_o = reg_i;
        endcase
    end

endmodule

// File: rtl/reg_file_fwd.sv
// rtl/reg_file_fwd.sv - ID-stage register file with write-first bypass, forwarding and clear sweep; option REGFILE_ZERO_REG_EN
module reg_file_fwd
    import regfile_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [1:0]        fwd_sel_a,
    input  logic [1:0]        fwd_sel_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              init_busy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    rf_state_t         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] ar_q, br_q;
    logic [DATA_W-1:0] ar_d, br_d;
    logic              busy_q;

    logic              wr_ok;
    logic              zero_a, zero_b;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] b_fwd;

`ifdef REGFILE_ZERO_REG_EN
    // Entry 0 reads as zero and never accepts writes, so it can never bypass either.
    assign wr_ok  = wr_en && (wr_addr != '0);
    assign zero_a = (ra_addr == '0);
    assign zero_b = (rb_addr == '0);
`else
    assign wr_ok  = wr_en;
    assign zero_a = 1'b0;
    assign zero_b = 1'b0;
`endif

    assign mem_we    = !rst && ((state_q == ST_INIT) || wr_ok);
    assign mem_waddr = (state_q == ST_INIT) ? cnt_q : wr_addr;
    assign mem_wdata = (state_q == ST_INIT) ? '0 : wr_data;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    // Write-first: a same-edge write to the read address wins over the stale array word.
    always_comb begin
        ar_d = mem_q[ra_addr];
        br_d = mem_q[rb_addr];
        if (wr_ok && (wr_addr == ra_addr))
            ar_d = wr_data;
        if (wr_ok && (wr_addr == rb_addr))
            br_d = wr_data;
        if (zero_a)
            ar_d = '0;
        if (zero_b)
            br_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ar_q    <= '0;
            br_q    <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (rd_en) begin
                        ar_q <= ar_d;
                        br_q <= br_d;
                    end
                end
            endcase
        end
    end

    assign init_busy = busy_q;

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
        .sel_i (fwd_sel_a),
        .reg_i (ar_q),
        .ex_i  (ans_ex),
        .dm_i  (ans_dm),
        .wb_i  (ans_wb),
        .y_o   (a)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
        .sel_i (fwd_sel_b),
        .reg_i (br_q),
        .ex_i  (ans_ex),
        .dm_i  (ans_dm),
        .wb_i  (ans_wb),
        .y_o   (b_fwd)
    );

    assign b = imm_sel ? imm : b_fwd;

endmodule
